// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_pkg
//  Purpose  : Shared opcodes, widths and FSM encodings for the shared
//             arithmetic-unit controller.
//  Revision : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int RES_W  = 64;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_MUL = 3'd2;
    localparam logic [OP_W-1:0] OP_DIV = 3'd3;
    localparam logic [OP_W-1:0] OP_AND = 3'd4;
    localparam logic [OP_W-1:0] OP_OR  = 3'd5;
    localparam logic [OP_W-1:0] OP_NOT = 3'd6;
    localparam logic [OP_W-1:0] OP_XOR = 3'd7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin arbiter. Searches upward from the
//             requester after last_grant and returns a one-hot grant plus
//             its binary index.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int              IDX_W = $clog2(N);
    localparam logic [IDX_W:0]  c_N   = (IDX_W+1)'(N);

    // First pending requester at (last_grant + k) mod N, k = 1..N
    always_comb begin : p_search
        logic [IDX_W:0] w_pos;
        logic           w_found;
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_pos     = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (w_pos >= c_N) begin
                w_pos = w_pos - c_N;
            end
            if (!w_found && req[w_pos[IDX_W-1:0]]) begin
                grant[w_pos[IDX_W-1:0]] = 1'b1;
                grant_idx               = w_pos[IDX_W-1:0];
                w_found                 = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_ctrl
//  Purpose  : Shares one registered-output arithmetic unit between NUM_REQ
//             requesters. One operation in flight; divide-by-zero is trapped
//             before the unit is issued.
//  Revision : 1.0  initial release
// ============================================================================
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OP_W*NUM_REQ-1:0]   req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_op1,
    input  logic [DATA_W*NUM_REQ-1:0] req_op2,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [RES_W-1:0]          rsp_result,
    output logic                      rsp_err,
    output logic [OP_W-1:0]           alu_operation,
    output logic [DATA_W-1:0]         alu_op1,
    output logic [DATA_W-1:0]         alu_op2,
    input  logic [RES_W-1:0]          alu_result,
    output logic                      busy
);

    localparam int               IDX_W       = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] c_LAST_INIT = IDX_W'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_last_grant;
    logic [NUM_REQ-1:0] r_gnt;
    logic [OP_W-1:0]    r_op;
    logic [DATA_W-1:0]  r_op1;
    logic [DATA_W-1:0]  r_op2;
    logic [RES_W-1:0]   r_result;
    logic               r_err;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [OP_W-1:0]    w_sel_op;
    logic [DATA_W-1:0]  w_sel_op1;
    logic [DATA_W-1:0]  w_sel_op2;
    logic               w_any;
    logic               w_trap;
    logic               w_rsp_taken;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_gnt_idx)
    );

    // Payload of the currently granted requester
    always_comb begin
        w_sel_op  = '0;
        w_sel_op1 = '0;
        w_sel_op2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_op  = req_op[OP_W*i +: OP_W];
                w_sel_op1 = req_op1[DATA_W*i +: DATA_W];
                w_sel_op2 = req_op2[DATA_W*i +: DATA_W];
            end
        end
    end

    assign w_any       = |req_valid;
    assign w_trap      = (w_sel_op == OP_DIV) && (w_sel_op2 == '0);
    assign w_rsp_taken = |(rsp_ready & r_gnt);

    // Accept-ready is suppressed while reset is asserted so no requester
    // believes it was accepted on an edge that the reset discards.
    assign req_ready     = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;
    assign rsp_valid     = (r_state == ST_RESP) ? r_gnt : '0;
    assign rsp_result    = r_result;
    assign rsp_err       = r_err;
    assign busy          = (r_state != ST_IDLE);
    assign alu_operation = (r_state == ST_ISSUE) ? r_op  : '0;
    assign alu_op1       = (r_state == ST_ISSUE) ? r_op1 : '0;
    assign alu_op2       = (r_state == ST_ISSUE) ? r_op2 : '0;

    // Controller FSM: accept, issue, capture the registered result, respond
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= c_LAST_INIT;
            r_gnt        <= '0;
            r_op         <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_result     <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt        <= w_grant;
                        r_last_grant <= w_gnt_idx;
                        r_op         <= w_sel_op;
                        r_op1        <= w_sel_op1;
                        r_op2        <= w_sel_op2;
                        if (w_trap) begin
                            r_result <= '0;
                            r_err    <= 1'b1;
                            r_state  <= ST_RESP;
                        end else begin
                            r_state  <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_result <= alu_result;
                    r_err    <= 1'b0;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_taken) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
